// File: rtl/encoder83_seq.sv
// encoder83_seq -- sequential 8-to-3 priority encoder.
//
// Captures a multi-hot request vector on an accepted load, then emits the
// index of each set bit, highest index first, one per valid/ready transfer.
//
// Optional feature macro: ENC_COUNT_EN (adds out_cnt = popcount of captured din).
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   load      capture request, accepted only while in_ready=1
//   din       request vector sampled on an accepted load
//   in_ready  block idle, able to accept load
//   out_valid out_code holds a valid index
//   out_ready consumer accepts out_code this cycle
//   out_code  index of highest set pending bit
//   out_last  out_code is the final set bit of the vector
//   done      one-cycle pulse when a captured vector is fully drained
//   zero      one-cycle pulse with done when the captured din was all zeros
//   out_cnt   (ENC_COUNT_EN only) number of set bits in the captured din
module encoder83_seq #(
    parameter int WIDTH = 8,
    parameter int IW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW-1:0]    out_code,
    output logic             out_last,
    output logic             done,
    output logic             zero
`ifdef ENC_COUNT_EN
    ,
    output logic [IW:0]      out_cnt
`endif
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pend;
    logic [WIDTH-1:0] w_pend_nxt;
    logic             r_done;
    logic             r_zero;
    logic             w_done_nxt;
    logic             w_zero_nxt;
    logic [IW-1:0]    w_msb;
    logic             w_any;
    logic             w_single;
    logic [WIDTH-1:0] w_code_mask;

    // Highest set bit of the registered pending vector: ascending scan,
    // later (higher) hits overwrite earlier ones.
    always_comb begin
        w_msb = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (r_pend[i]) begin
                w_msb = IW'(i);
            end
        end
    end

    always_comb begin
        w_any       = |r_pend;
        // x & (x-1) clears the lowest set bit; zero result means one bit set.
        w_single    = w_any && ((r_pend & (r_pend - WIDTH'(1))) == '0);
        w_code_mask = WIDTH'(1) << w_msb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_done  <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_done  <= w_done_nxt;
            r_zero  <= w_zero_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_done_nxt  = 1'b0;
        w_zero_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_pend_nxt = din;
                    if (din != '0) begin
                        w_state_nxt = SCAN;
                    end else begin
                        w_done_nxt = 1'b1;
                        w_zero_nxt = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (out_ready) begin
                    w_pend_nxt = r_pend & ~w_code_mask;
                    if (w_single) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == SCAN);
        out_code  = out_valid ? w_msb : '0;
        out_last  = out_valid && w_single;
        done      = r_done;
        zero      = r_zero;
    end

`ifdef ENC_COUNT_EN
    logic [IW:0] r_cnt;
    logic [IW:0] w_cnt;

    always_comb begin
        w_cnt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_cnt = w_cnt + (IW+1)'(din[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == IDLE && load) begin
            r_cnt <= w_cnt;
        end
    end

    assign out_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_encoder83_seq.sv
module tb_encoder83_seq;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [7:0] din;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_code;
    logic       out_last;
    logic       done;
    logic       zero;
`ifdef ENC_COUNT_EN
    logic [3:0] out_cnt;
`endif

    encoder83_seq #(.WIDTH(8), .IW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .din       (din),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_last  (out_last),
        .done      (done),
        .zero      (zero)
`ifdef ENC_COUNT_EN
        ,
        .out_cnt   (out_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of indices still to be emitted, highest first.
    int   q[$];
    bit   m_done;
    bit   m_zero;
    int   m_cnt;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_done = 0;
        m_zero = 0;
        m_cnt  = 0;
    endtask

    // Advance the model across one clock edge with the given inputs.
    task automatic model_step(input bit l, input logic [7:0] d, input bit r);
        bit nd;
        bit nz;
        logic [7:0] dv;
        nd = 0;
        nz = 0;
        dv = d;
        if (q.size() == 0) begin
            if (l) begin
                for (int i = 7; i >= 0; i--) begin
                    if (dv[i]) q.push_back(i);
                end
                m_cnt = $countones(dv);
                if (dv == 8'h00) begin
                    nd = 1;
                    nz = 1;
                end
            end
        end else if (r) begin
            void'(q.pop_front());
            if (q.size() == 0) nd = 1;
        end
        m_done = nd;
        m_zero = nz;
    endtask

    task automatic check_all();
        bit v;
        v = (q.size() != 0);
        chk("in_ready", int'(in_ready), int'(!v));
        chk("out_valid", int'(out_valid), int'(v));
        if (v) begin
            chk("out_code", int'(out_code), q[0]);
            chk("out_last", int'(out_last), int'(q.size() == 1));
        end else begin
            chk("out_last_idle", int'(out_last), 0);
        end
        chk("done", int'(done), int'(m_done));
        chk("zero", int'(zero), int'(m_zero));
`ifdef ENC_COUNT_EN
        chk("out_cnt", int'(out_cnt), m_cnt);
`endif
    endtask

    // Drive inputs, step the model, take the edge, then compare.
    task automatic tick(input bit l, input logic [7:0] d, input bit r);
        load      = l;
        din       = d;
        out_ready = r;
        model_step(l, d, r);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [7:0] rd;
        rst_n     = 1'b0;
        load      = 1'b0;
        din       = 8'h00;
        out_ready = 1'b0;
        model_reset();
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_code", int'(out_code), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_zero", int'(zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 8'h94 -> 7,4,2 then done
        tick(1, 8'h94, 1);
        chk("h94_c0", int'(out_code), 7);
        chk("h94_l0", int'(out_last), 0);
        tick(0, 8'h00, 1);
        chk("h94_c1", int'(out_code), 4);
        tick(0, 8'h00, 1);
        chk("h94_c2", int'(out_code), 2);
        chk("h94_l2", int'(out_last), 1);
        tick(0, 8'h00, 1);
        chk("h94_done", int'(done), 1);
        chk("h94_rdy", int'(in_ready), 1);
        tick(0, 8'h00, 1);
        chk("h94_done_end", int'(done), 0);

        // 8'h81 with out_ready 0,1,0,0,1
        tick(1, 8'h81, 0);
        tick(0, 8'h00, 0);
        chk("h81_hold7", int'(out_code), 7);
        tick(0, 8'h00, 1);
        chk("h81_c0", int'(out_code), 0);
        tick(0, 8'h00, 0);
        tick(0, 8'h00, 0);
        chk("h81_hold0", int'(out_code), 0);
        tick(0, 8'h00, 1);
        chk("h81_done", int'(done), 1);

        // all-zero vector
        tick(1, 8'h00, 1);
        chk("z_done", int'(done), 1);
        chk("z_zero", int'(zero), 1);
        chk("z_valid", int'(out_valid), 0);
        tick(0, 8'h00, 1);
        chk("z_zero_end", int'(zero), 0);

        // back-to-back: 01, 10 ignored during SCAN, 02 in done cycle
        tick(1, 8'h01, 1);
        chk("bb_c0", int'(out_code), 0);
        tick(1, 8'h10, 1);
        chk("bb_done1", int'(done), 1);
        tick(1, 8'h02, 1);
        chk("bb_c1", int'(out_code), 1);
        chk("bb_l1", int'(out_last), 1);
`ifdef ENC_COUNT_EN
        chk("bb_cnt", int'(out_cnt), 1);
`endif
        tick(0, 8'h00, 1);
        chk("bb_done2", int'(done), 1);

        // 8'hFF -> 7..0
        tick(1, 8'hFF, 1);
`ifdef ENC_COUNT_EN
        chk("ff_cnt", int'(out_cnt), 8);
`endif
        for (int k = 7; k >= 0; k--) begin
            chk("ff_code", int'(out_code), k);
            chk("ff_last", int'(out_last), int'(k == 0));
            tick(0, 8'h00, 1);
        end
        chk("ff_done", int'(done), 1);

        // async reset mid-SCAN after two codes of 8'hA5
        tick(1, 8'hA5, 1);
        tick(0, 8'h00, 1);
        tick(0, 8'h00, 1);
        chk("a5_c2", int'(out_code), 2);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_ready", int'(in_ready), 1);
        chk("mid_rst_done", int'(done), 0);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) tick(0, 8'h00, 1);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            case ($urandom_range(0, 3))
                0: rd = 8'h00;
                1: rd = 8'h01 << $urandom_range(0, 7);
                default: rd = 8'($urandom);
            endcase
            tick(($urandom_range(0, 2) == 0), rd, ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
